// File: rtl/rasm_uart_pkg.sv
// Shared types and defaults for the host-side UART command front end.
//   asm_state_t : command assembler states (HIGH, LOW, READY)
//   tx_state_t  : response transmitter states (IDLE, START, DATA, STOP)
//   rx_state_t  : receiver states
//   BAUD_DIV_DEF: clk cycles per UART bit (100 MHz / 57600)
package rasm_uart_pkg;
  localparam int BAUD_DIV_DEF = 1736;

  typedef enum logic [1:0] {HIGH, LOW, READY} asm_state_t;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, start-bit glitch check, 8N1 sampling.
//   clk, rst   : clock, async active-high reset
//   rx         : raw serial input (idles high)
//   rx_data    : received byte, valid with rx_vld
//   rx_vld     : 1-cycle pulse, byte received with good stop bit
//   frame_err  : 1-cycle pulse, stop bit read 0 (byte dropped)
module uart_rx
  import rasm_uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_vld,
  output logic       frame_err
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

  logic      sync1_q, sync2_q, prev_q;
  rx_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic       vld_q, vld_d, ferr_q, ferr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      vld_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      vld_q   <= vld_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    vld_d   = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      // Falling edge needs a high sample before it, so after a framing
      // error with RX stuck low we only rearm once the line returns high.
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (prev_q && !sync2_q) state_d = RX_START;
      end
      RX_START: if (cnt_q == HALF_LAST) begin
        cnt_d   = '0;
        state_d = sync2_q ? RX_IDLE : RX_DATA;  // high at mid-bit: glitch
      end
      RX_DATA: if (cnt_q == BIT_LAST) begin
        cnt_d = '0;
        sh_d  = {sync2_q, sh_q[7:1]};
        bit_d = bit_q + 4'd1;
        if (bit_d >= 4'd8) begin
          bit_d   = '0;
          state_d = RX_STOP;
        end
      end
      RX_STOP: if (cnt_q == BIT_LAST) begin
        cnt_d   = '0;
        state_d = RX_IDLE;
        if (sync2_q) vld_d = 1'b1;
        else         ferr_d = 1'b1;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign rx_data   = sh_q;
  assign rx_vld    = vld_q;
  assign frame_err = ferr_q;
endmodule

// File: rtl/uart_cmd_wrapper.sv
// Host-side serial front end for the command/config unit.
// Two RX bytes (high then low) form a 16-bit cmd; an 8-bit resp is sent back.
//   clk, rst    : clock, async active-high reset
//   RX / TX     : serial from / to host, both idle high
//   cmd,cmd_rdy : assembled command, held until clr_cmd_rdy
//   clr_cmd_rdy : 1-cycle pulse, drops cmd_rdy
//   resp,send_resp : byte to send, 1-cycle start pulse (ignored while busy)
//   resp_sent   : 1-cycle pulse at end of the stop bit
//   frame_err   : 1-cycle pulse on a bad received stop bit
module uart_cmd_wrapper
  import rasm_uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        frame_err
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BIT_LAST = CW'(BAUD_DIV - 1);

  logic [7:0] rx_data;
  logic       rx_vld, rx_ferr;

  uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk(clk), .rst(rst), .rx(RX),
    .rx_data(rx_data), .rx_vld(rx_vld), .frame_err(rx_ferr)
  );

  // Command assembler
  asm_state_t asm_q, asm_d;
  logic [15:0] cmd_q, cmd_d;
  logic        rdy_q, rdy_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q <= HIGH;
      cmd_q <= '0;
      rdy_q <= 1'b0;
    end else begin
      asm_q <= asm_d;
      cmd_q <= cmd_d;
      rdy_q <= rdy_d;
    end
  end

  always_comb begin
    asm_d = asm_q;
    cmd_d = cmd_q;
    rdy_d = rdy_q;
    case (asm_q)
      HIGH: if (rx_vld) begin
        cmd_d[15:8] = rx_data;
        asm_d       = LOW;
      end
      LOW: begin
        if (rx_vld) begin
          cmd_d[7:0] = rx_data;
          rdy_d      = 1'b1;
          asm_d      = READY;
        end else if (rx_ferr) begin
          asm_d = HIGH;  // resync: abandon the stored high byte
        end
      end
      READY: if (clr_cmd_rdy) begin
        rdy_d = 1'b0;
        // A byte arriving with the clear starts the next command.
        if (rx_vld) begin
          cmd_d[15:8] = rx_data;
          asm_d       = LOW;
        end else begin
          asm_d = HIGH;
        end
      end
      default: asm_d = HIGH;
    endcase
  end

  // Response transmitter; latched byte stays intact, bits picked by index
  tx_state_t tx_st_q, tx_st_d;
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic [3:0]    tbit_q, tbit_d;
  logic [7:0]    tbyte_q, tbyte_d;
  logic          tx_q, tx_d, sent_q, sent_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_st_q <= IDLE;
      tcnt_q  <= '0;
      tbit_q  <= '0;
      tbyte_q <= '0;
      tx_q    <= 1'b1;
      sent_q  <= 1'b0;
    end else begin
      tx_st_q <= tx_st_d;
      tcnt_q  <= tcnt_d;
      tbit_q  <= tbit_d;
      tbyte_q <= tbyte_d;
      tx_q    <= tx_d;
      sent_q  <= sent_d;
    end
  end

  always_comb begin
    tx_st_d = tx_st_q;
    tcnt_d  = tcnt_q + 1'b1;
    tbit_d  = tbit_q;
    tbyte_d = tbyte_q;
    tx_d    = tx_q;
    sent_d  = 1'b0;
    case (tx_st_q)
      IDLE: begin
        tcnt_d = '0;
        tbit_d = '0;
        if (send_resp) begin
          tbyte_d = resp;
          tx_d    = 1'b0;
          tx_st_d = START;
        end
      end
      START: if (tcnt_q == BIT_LAST) begin
        tcnt_d  = '0;
        tx_d    = tbyte_q[0];
        tx_st_d = DATA;
      end
      DATA: if (tcnt_q == BIT_LAST) begin
        tcnt_d = '0;
        tbit_d = tbit_q + 4'd1;
        if (tbit_d >= 4'd8) begin
          tbit_d  = '0;
          tx_d    = 1'b1;
          tx_st_d = STOP;
        end else begin
          tx_d = tbyte_q[tbit_d[2:0]];
        end
      end
      STOP: if (tcnt_q == BIT_LAST) begin
        tcnt_d  = '0;
        sent_d  = 1'b1;
        tx_st_d = IDLE;
      end
      default: tx_st_d = IDLE;
    endcase
  end

  assign TX        = tx_q;
  assign cmd       = cmd_q;
  assign cmd_rdy   = rdy_q;
  assign resp_sent = sent_q;
  assign frame_err = rx_ferr;
endmodule

// File: tb/tb_uart_cmd_wrapper.sv
module tb_uart_cmd_wrapper;
  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RX = 1'b1;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic [7:0]  resp = '0;
  logic        send_resp = 1'b0;
  logic        resp_sent, frame_err;

  int n_vec = 0, n_err = 0;
  int n_sent = 0, n_fe = 0;

  uart_cmd_wrapper #(.BAUD_DIV(BD)) dut (
    .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp),
    .resp_sent(resp_sent), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (resp_sent) n_sent++;
    if (frame_err) n_fe++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One 8N1 frame on RX, driven on negedges; optional clr pulse at negedge clr_at.
  task automatic uart_send(input logic [7:0] b, input logic stopb, input int clr_at);
    logic [9:0] fr;
    fr = {stopb, b, 1'b0};
    @(negedge clk);
    for (int n = 0; n < 10*BD; n++) begin
      RX = fr[n/BD];
      clr_cmd_rdy = (n == clr_at);
      @(negedge clk);
    end
    RX = 1'b1;
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic pulse_clr;
    @(negedge clk) clr_cmd_rdy = 1'b1;
    @(negedge clk) clr_cmd_rdy = 1'b0;
  endtask

  // Send resp b, optionally retrigger with inj_val at cycle inj_at; capture
  // mid-bit TX samples and the edge count to resp_sent.
  task automatic tx_capture(input logic [7:0] b, input int inj_at, input logic [7:0] inj_val,
                            output logic [9:0] bits, output int lat);
    bits = '0;
    lat = -1;
    @(negedge clk);
    resp = b;
    send_resp = 1'b1;
    @(posedge clk);
    #1 send_resp = 1'b0;
    for (int c = 1; c <= 10*BD + 10; c++) begin
      @(posedge clk);
      #1;
      if (c % BD == BD/2 && c / BD < 10) bits[c/BD] = TX;
      if (resp_sent && lat < 0) lat = c;
      if (c == inj_at) begin
        resp = inj_val;
        send_resp = 1'b1;
      end else begin
        send_resp = 1'b0;
      end
    end
  endtask

  initial begin
    logic [9:0] bits;
    int lat, hold, fe0, s0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", TX, 1);
    chk("rst_cmd", cmd, 16'h0000);
    chk("rst_rdy", cmd_rdy, 0);
    chk("rst_sent", resp_sent, 0);
    chk("rst_fe", frame_err, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 1: two bytes -> cmd, hold until clear
    uart_send(8'h47, 1'b1, -1);
    chk("t1_rdy_early", cmd_rdy, 0);
    uart_send(8'h2A, 1'b1, -1);
    chk("t1_cmd", cmd, 16'h472A);
    chk("t1_rdy", cmd_rdy, 1);
    hold = 0;
    repeat (100) begin
      @(negedge clk);
      if (cmd_rdy) hold++;
    end
    chk("t1_hold", hold, 100);
    pulse_clr();
    chk("t1_clr", cmd_rdy, 0);

    // 2: transmit 0xA5
    s0 = n_sent;
    tx_capture(8'hA5, -1, 8'h00, bits, lat);
    chk("t2_bits", bits, 10'b1_1010_0101_0);
    chk("t2_lat", lat, 160);
    @(negedge clk);
    chk("t2_pulses", n_sent - s0, 1);
    chk("t2_idle", TX, 1);

    // 3: framing error resyncs the assembler
    fe0 = n_fe;
    uart_send(8'h12, 1'b1, -1);
    uart_send(8'h77, 1'b0, -1);
    repeat (20) @(negedge clk);
    chk("t3_fe", n_fe - fe0, 1);
    chk("t3_rdy0", cmd_rdy, 0);
    uart_send(8'h34, 1'b1, -1);
    uart_send(8'h56, 1'b1, -1);
    chk("t3_cmd", cmd, 16'h3456);
    chk("t3_rdy", cmd_rdy, 1);
    chk("t3_fe_once", n_fe - fe0, 1);

    // 4: drop while ready; clear coincident with rx_vld
    uart_send(8'h99, 1'b1, -1);
    repeat (5) @(negedge clk);
    chk("t4_frozen", cmd, 16'h3456);
    chk("t4_rdy_held", cmd_rdy, 1);
    uart_send(8'hAB, 1'b1, 155);
    chk("t4_clr", cmd_rdy, 0);
    chk("t4_hi", cmd[15:8], 8'hAB);
    uart_send(8'hCD, 1'b1, -1);
    chk("t4_cmd", cmd, 16'hABCD);
    chk("t4_rdy", cmd_rdy, 1);
    pulse_clr();

    // 5a: send_resp while busy is ignored
    s0 = n_sent;
    tx_capture(8'h3C, 40, 8'hFF, bits, lat);
    chk("t5_bits", bits, 10'b1_0011_1100_0);
    chk("t5_lat", lat, 160);
    repeat (200) @(negedge clk);
    chk("t5_pulses", n_sent - s0, 1);
    chk("t5_idle", TX, 1);

    // 5b: reset 80 cycles into a frame of 0x00
    s0 = n_sent;
    @(negedge clk);
    resp = 8'h00;
    send_resp = 1'b1;
    @(posedge clk);
    #1 send_resp = 1'b0;
    repeat (79) @(posedge clk);
    #1;
    chk("t5_mid_tx", TX, 0);
    rst = 1'b1;
    #1;
    chk("t5_rst_tx", TX, 1);
    chk("t5_rst_cmd", cmd, 16'h0000);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (150) @(negedge clk);
    chk("t5_no_sent", n_sent - s0, 0);
    chk("t5_tx_hi", TX, 1);

    // 6: short RX glitch is rejected
    fe0 = n_fe;
    @(negedge clk) RX = 1'b0;
    repeat (5) @(negedge clk);
    RX = 1'b1;
    repeat (200) @(negedge clk);
    chk("t6_fe", n_fe - fe0, 0);
    chk("t6_rdy", cmd_rdy, 0);
    chk("t6_cmd", cmd, 16'h0000);
    uart_send(8'h11, 1'b1, -1);
    uart_send(8'h22, 1'b1, -1);
    chk("t6_cmd_after", cmd, 16'h1122);
    chk("t6_rdy_after", cmd_rdy, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
